// File: rtl/prog_load_ctrl_if.sv
// Host program-load port of prog_load_ctrl: start/length, valid/ready word stream, done pulse.
// PROG_LOAD_CHECKSUM_EN adds the host_chk input and the chk_sum/chk_err results.
interface prog_load_ctrl_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 3
);
  logic              host_start;
  logic [ADDR_W-1:0] host_len;
  logic              host_valid;
  logic [DATA_W-1:0] host_data;
  logic              host_ready;
  logic              host_done;
`ifdef PROG_LOAD_CHECKSUM_EN
  logic [ADDR_W-1:0] host_chk;
  logic [ADDR_W-1:0] chk_sum;
  logic              chk_err;
`endif

`ifdef PROG_LOAD_CHECKSUM_EN
  modport master (
    output host_start, host_len, host_valid, host_data, host_chk,
    input  host_ready, host_done, chk_sum, chk_err
  );
  modport slave (
    input  host_start, host_len, host_valid, host_data, host_chk,
    output host_ready, host_done, chk_sum, chk_err
  );
`else
  modport master (
    output host_start, host_len, host_valid, host_data,
    input  host_ready, host_done
  );
  modport slave (
    input  host_start, host_len, host_valid, host_data,
    output host_ready, host_done
  );
`endif
endinterface

// File: rtl/prog_load_ctrl.sv
// Run/load sequencer for the 3-bit Forth core: stalls the core, streams host words into RAM,
// then resets and releases the core. Optional checksum gate: PROG_LOAD_CHECKSUM_EN.
module prog_load_ctrl #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DATA_W     = 3,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned BOOT_RUN   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  prog_load_ctrl_if.slave   host,
  input  logic              core_p,
  input  logic              core_halt,
  output logic              core_run_en,
  output logic              core_rst_n,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              busy,
  output logic              halted
);

  typedef enum logic [2:0] {StIdle, StRun, StStall, StLoad, StRelease} state_e;

  localparam state_e            BootState = (BOOT_RUN != 0) ? StRun : StIdle;
  localparam logic [ADDR_W-1:0] StartAddr = ADDR_W'(START_ADDR);
  localparam logic [3:0]        RstLast   = 4'(RST_CYCLES - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_inc;
  logic [3:0]        rst_cnt_q;
  logic              host_ready_q;
  logic              host_done_q;
  logic              accept;
  logic              last_word;
  logic              chk_ok;

  // host_ready_q is only ever set while in LOAD with mem_sel high
  assign accept    = host_ready_q & host.host_valid;
  assign cnt_inc   = cnt_q + ADDR_W'(1);
  assign last_word = (len_q == '0) | (accept & (cnt_inc == len_q));

  assign mem_we          = mem_sel & accept;
  assign mem_wdata       = host.host_data;
  assign host.host_ready = host_ready_q;
  assign host.host_done  = host_done_q;
  assign busy            = (state_q != StRun) && (state_q != StIdle);

`ifdef PROG_LOAD_CHECKSUM_EN
  logic [ADDR_W-1:0] chk_q;
  logic [ADDR_W-1:0] sum_q;
  logic [ADDR_W-1:0] sum_d;
  logic              chk_err_q;

  // Sum includes the word accepted on the final LOAD edge
  assign sum_d        = accept ? sum_q + ADDR_W'(host.host_data) : sum_q;
  assign chk_ok       = (sum_d == chk_q);
  assign host.chk_sum = sum_q;
  assign host.chk_err = chk_err_q;
`else
  assign chk_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BootState;
      core_run_en  <= (BOOT_RUN != 0);
      core_rst_n   <= 1'b1;
      mem_sel      <= 1'b0;
      host_ready_q <= 1'b0;
      host_done_q  <= 1'b0;
      halted       <= 1'b0;
      mem_addr     <= StartAddr;
      cnt_q        <= '0;
      len_q        <= '0;
      rst_cnt_q    <= '0;
`ifdef PROG_LOAD_CHECKSUM_EN
      chk_q        <= '0;
      sum_q        <= '0;
      chk_err_q    <= 1'b0;
`endif
    end else begin
      host_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (host.host_start) begin
            state_q      <= StLoad;
            mem_sel      <= 1'b1;
            host_ready_q <= (host.host_len != '0);
          end
        end
        StRun: begin
          if (host.host_start) begin
            state_q <= StStall;
          end else if (core_halt) begin
            state_q     <= StIdle;
            halted      <= 1'b1;
            core_run_en <= 1'b0;
          end
        end
        StStall: begin
          // core_p high means this cycle completes phase 2
          if (core_p) begin
            state_q      <= StLoad;
            core_run_en  <= 1'b0;
            mem_sel      <= 1'b1;
            host_ready_q <= (len_q != '0);
          end
        end
        StLoad: begin
          if (accept) begin
            mem_addr <= mem_addr + ADDR_W'(1);
            cnt_q    <= cnt_inc;
          end
`ifdef PROG_LOAD_CHECKSUM_EN
          sum_q <= sum_d;
`endif
          if (last_word) begin
            host_ready_q <= 1'b0;
            mem_sel      <= 1'b0;
            host_done_q  <= 1'b1;
            if (chk_ok) begin
              state_q    <= StRelease;
              core_rst_n <= 1'b0;
              rst_cnt_q  <= '0;
              halted     <= 1'b0;
            end else begin
              state_q <= StIdle;
`ifdef PROG_LOAD_CHECKSUM_EN
              chk_err_q <= 1'b1;
`endif
            end
          end
        end
        StRelease: begin
          if (rst_cnt_q == RstLast) begin
            core_rst_n  <= 1'b1;
            core_run_en <= 1'b1;
            state_q     <= StRun;
          end else begin
            rst_cnt_q <= rst_cnt_q + 4'd1;
          end
        end
        default: state_q <= BootState;
      endcase

      // Session start is accepted only from RUN or IDLE
      if ((state_q == StRun || state_q == StIdle) && host.host_start) begin
        len_q    <= host.host_len;
        cnt_q    <= '0;
        mem_addr <= StartAddr;
`ifdef PROG_LOAD_CHECKSUM_EN
        chk_q     <= host.host_chk;
        sum_q     <= '0;
        chk_err_q <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Self-checking bench for prog_load_ctrl: two instances (load base 0 and 4094) share stimulus.
// Checksum scenarios are compiled in with PROG_LOAD_CHECKSUM_EN.
module tb_prog_load_ctrl;
  localparam int unsigned AW     = 12;
  localparam int unsigned DW     = 3;
  localparam int unsigned RSTC   = 2;
  localparam int unsigned START1 = 4094;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          host_start, host_valid, core_p, core_halt;
  logic [AW-1:0] host_len;
  logic [DW-1:0] host_data;
  bit            p_auto;

  logic          run_en0, crst0, sel0, we0, busy0, halted0;
  logic          run_en1, crst1, sel1, we1, busy1, halted1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;

  prog_load_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) if0 ();
  prog_load_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();

  assign if0.host_start = host_start;
  assign if0.host_len   = host_len;
  assign if0.host_valid = host_valid;
  assign if0.host_data  = host_data;
  assign if1.host_start = host_start;
  assign if1.host_len   = host_len;
  assign if1.host_valid = host_valid;
  assign if1.host_data  = host_data;
`ifdef PROG_LOAD_CHECKSUM_EN
  logic [AW-1:0] host_chk;
  assign if0.host_chk = host_chk;
  assign if1.host_chk = host_chk;
`endif

  prog_load_ctrl #(.ADDR_W(AW), .DATA_W(DW), .START_ADDR(0), .RST_CYCLES(RSTC), .BOOT_RUN(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .host(if0), .core_p(core_p), .core_halt(core_halt),
    .core_run_en(run_en0), .core_rst_n(crst0), .mem_sel(sel0), .mem_addr(addr0),
    .mem_wdata(wdata0), .mem_we(we0), .busy(busy0), .halted(halted0)
  );

  prog_load_ctrl #(.ADDR_W(AW), .DATA_W(DW), .START_ADDR(START1), .RST_CYCLES(RSTC),
                   .BOOT_RUN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .host(if1), .core_p(core_p), .core_halt(core_halt),
    .core_run_en(run_en1), .core_rst_n(crst1), .mem_sel(sel1), .mem_addr(addr1),
    .mem_wdata(wdata1), .mem_we(we1), .busy(busy1), .halted(halted1)
  );

  // Observed RAM writes and pulse counters (model compares deltas per session)
  logic [AW+DW-1:0] wq0[$];
  logic [AW+DW-1:0] wq1[$];
  int done0 = 0, done1 = 0, rlow0 = 0, rlow1 = 0, bad_we = 0;

  always @(posedge clk) begin
    if (we0) wq0.push_back({addr0, wdata0});
    if (we1) wq1.push_back({addr1, wdata1});
    if (if0.host_done) done0++;
    if (if1.host_done) done1++;
    if (!crst0) rlow0++;
    if (!crst1) rlow1++;
    if ((we0 && !sel0) || (we1 && !sel1)) bad_we++;
  end

  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] words[16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    if (p_auto) core_p = ~core_p;
  endtask

  // One load session; stop_after >= 0 asserts rst_n after that many accepted words
  task automatic session(input int len, input int stop_after, input bit extra_start,
                         input bit bad_chk, input bit stall_check);
    int b0, b1, d0, d1, r0, r1, idx, guard, nexp, mism;
    bit acc;
    logic [AW-1:0] sum;
    b0 = wq0.size(); b1 = wq1.size();
    d0 = done0; d1 = done1; r0 = rlow0; r1 = rlow1;
    sum = '0;
    for (int i = 0; i < len; i++) sum = sum + AW'(words[i]);
`ifdef PROG_LOAD_CHECKSUM_EN
    host_chk = bad_chk ? sum - AW'(1) : sum;
`endif
    if (stall_check) begin
      p_auto = 1'b0;
      core_p = 1'b0;
    end
    host_start = 1'b1;
    host_len   = AW'(len);
    tick();
    host_start = 1'b0;
    host_len   = AW'($urandom);
    if (len == 0) begin
      check("len0_mem_sel", 32'(sel0), 1);
      check("len0_ready", 32'(if0.host_ready), 0);
    end
    if (stall_check) begin
      for (int k = 0; k < 2; k++) begin
        check("stall_run_en", 32'(run_en0), 1);
        check("stall_mem_sel", 32'(sel0), 0);
        tick();
      end
      core_p = 1'b1;
      tick();
      check("stall_exit_run_en", 32'(run_en0), 0);
      check("stall_exit_mem_sel", 32'(sel0), 1);
      core_p = 1'b0;
      p_auto = 1'b1;
    end
    idx = 0;
    guard = 0;
    while (idx < len && guard < 100 && !(stop_after >= 0 && idx == stop_after)) begin
      host_valid = ($urandom_range(0, 2) != 0);
      host_data  = words[idx];
      host_start = extra_start && (idx == 1);
      if (host_start) host_len = AW'(1);
      acc = host_valid && if0.host_ready;
      tick();
      if (acc) idx++;
      guard++;
    end
    host_start = 1'b0;
    check("load_within_bound", 32'(guard < 100), 1);
    if (stop_after >= 0) begin
      host_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midrst_mem_sel", 32'(sel0), 0);
      check("midrst_ready", 32'(if0.host_ready), 0);
      check("midrst_run_en", 32'(run_en0), 1);
      check("midrst_busy", 32'(busy0), 0);
      check("midrst_addr0", 32'(addr0), 0);
      check("midrst_addr1", 32'(addr1), START1);
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      check("midrst_no_done", 32'(done0 - d0), 0);
      nexp = stop_after;
    end else begin
      // Keep offering words past the end: none may be accepted
      host_valid = 1'b1;
      host_data  = DW'($urandom);
      tick();
      tick();
      host_valid = 1'b0;
      guard = 0;
      while (busy0 && guard < 30) begin
        tick();
        guard++;
      end
      check("back_to_idle_run", 32'(busy0), 0);
      check("done_pulses0", 32'(done0 - d0), 1);
      check("done_pulses1", 32'(done1 - d1), 1);
      if (bad_chk) begin
        check("chkerr_rst_low", 32'(rlow0 - r0), 0);
        check("chkerr_run_en", 32'(run_en0), 0);
      end else begin
        check("rst_low_cycles0", 32'(rlow0 - r0), RSTC);
        check("rst_low_cycles1", 32'(rlow1 - r1), RSTC);
        check("released_run_en", 32'(run_en0), 1);
        check("released_core_rst_n", 32'(crst0), 1);
        check("released_halted", 32'(halted0), 0);
      end
      nexp = len;
    end
    check("write_count0", 32'(wq0.size() - b0), 32'(nexp));
    check("write_count1", 32'(wq1.size() - b1), 32'(nexp));
    mism = 0;
    for (int i = 0; i < nexp; i++) begin
      if (b0 + i < wq0.size() && wq0[b0+i] !== {AW'(i), words[i]}) mism++;
      if (b1 + i < wq1.size() && wq1[b1+i] !== {AW'(START1 + i), words[i]}) mism++;
    end
    check("write_addr_data", 32'(mism), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    rst_n = 1'b0;
    host_start = 1'b0; host_valid = 1'b0; host_len = '0; host_data = '0;
    core_p = 1'b0; core_halt = 1'b0; p_auto = 1'b1;
`ifdef PROG_LOAD_CHECKSUM_EN
    host_chk = '0;
`endif
    #12;
    check("rst_run_en", 32'(run_en0), 1);
    check("rst_core_rst_n", 32'(crst0), 1);
    check("rst_mem_sel", 32'(sel0), 0);
    check("rst_busy", 32'(busy0), 0);
    check("rst_mem_addr0", 32'(addr0), 0);
    check("rst_mem_addr1", 32'(addr1), START1);
    check("rst_halted", 32'(halted0), 0);
    check("rst_ready_done", 32'({if0.host_ready, if0.host_done}), 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("run_after_rst", 32'({run_en0, crst0, busy0, sel0}), 32'b1100);

    // Directed program with stall at phase boundary
    words[0] = 3'd5; words[1] = 3'd1; words[2] = 3'd7; words[3] = 3'd2;
    session(4, -1, 1'b0, 1'b0, 1'b1);

    // Three words: second instance wraps 4094, 4095, 0
    for (int i = 0; i < 3; i++) words[i] = DW'($urandom);
    session(3, -1, 1'b0, 1'b0, 1'b0);

    // Halt to IDLE, then empty load from IDLE
    core_halt = 1'b1;
    tick();
    core_halt = 1'b0;
    tick();
    check("halt_halted", 32'(halted0), 1);
    check("halt_run_en", 32'(run_en0), 0);
    check("halt_busy", 32'(busy0), 0);
    session(0, -1, 1'b0, 1'b0, 1'b0);

    // Reset after 2 of 5 words
    for (int i = 0; i < 5; i++) words[i] = DW'($urandom);
    session(5, 2, 1'b0, 1'b0, 1'b0);

    // Second host_start during LOAD is ignored
    for (int i = 0; i < 3; i++) words[i] = DW'($urandom);
    session(3, -1, 1'b1, 1'b0, 1'b0);

    for (int s = 0; s < 4; s++) begin
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) words[i] = DW'($urandom);
      session(len, -1, 1'b0, 1'b0, 1'b0);
    end

`ifdef PROG_LOAD_CHECKSUM_EN
    words[0] = 3'd7; words[1] = 3'd7; words[2] = 3'd1;
    session(3, -1, 1'b0, 1'b0, 1'b0);
    check("chk_sum_good", 32'(if0.chk_sum), 15);
    check("chk_err_good", 32'(if0.chk_err), 0);
    session(3, -1, 1'b0, 1'b1, 1'b0);
    check("chk_err_bad", 32'(if0.chk_err), 1);
    check("chk_err_bad1", 32'(if1.chk_err), 1);
`endif

    check("we_only_with_sel", 32'(bad_we), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
